ifu: RTL



---
 rtl/ifu.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: single outstanding imem request, one-entry instruction buffer, redirect squash.
// Optional macro IFU_MISALIGN_CHECK_EN: misaligned redirect targets become fault markers instead of fetches.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd,
  output logic [31:0] cmd_pc,
  output logic        cmd_fault
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nx;
  logic        r_drop;
  logic        w_drop_nx;
  logic        r_mis_pend;
  logic        w_mis_pend_nx;
  logic [31:0] r_cmd;
  logic [31:0] r_cmd_pc;
  logic        r_fault;
  logic        w_buf_load;
  logic        w_mis_load;
  logic        w_misalign;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = {redirect_pc[31:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
  assign w_misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_drop_nx     = r_drop;
    w_mis_pend_nx = r_mis_pend;
    w_buf_load    = 1'b0;
    w_mis_load    = 1'b0;
    case (r_state)
      S_REQ: begin
        if (redirect_valid) begin
          w_pc_nx = w_redir_pc;
          if (imem_req_ready) begin
            // the old request is already accepted: wait out its response, then honour the redirect
            w_state_nx    = S_WAIT;
            w_drop_nx     = 1'b1;
            w_mis_pend_nx = w_misalign;
            w_mis_load    = w_misalign;
          end else if (w_misalign) begin
            w_state_nx = S_HOLD;
            w_mis_load = 1'b1;
          end
        end else if (imem_req_ready) begin
          w_state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          w_pc_nx       = w_redir_pc;
          w_mis_pend_nx = w_misalign;
          w_mis_load    = w_misalign;
          if (imem_resp_valid) begin
            w_drop_nx     = 1'b0;
            w_mis_pend_nx = 1'b0;
            w_state_nx    = w_misalign ? S_HOLD : S_REQ;
          end else begin
            w_drop_nx = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (r_drop) begin
            w_drop_nx     = 1'b0;
            w_mis_pend_nx = 1'b0;
            w_state_nx    = r_mis_pend ? S_HOLD : S_REQ;
          end else begin
            w_buf_load = 1'b1;
            w_state_nx = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_nx = w_redir_pc;
          if (w_misalign) begin
            w_mis_load = 1'b1;
          end else begin
            w_state_nx = S_REQ;
          end
        end else if (cmd_ready) begin
          w_pc_nx    = r_pc + 32'd4;
          w_state_nx = S_REQ;
        end
      end
      default: w_state_nx = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_drop     <= 1'b0;
      r_mis_pend <= 1'b0;
      r_cmd      <= NOP;
      r_cmd_pc   <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_drop     <= w_drop_nx;
      r_mis_pend <= w_mis_pend_nx;
      if (w_buf_load) begin
        r_cmd    <= imem_resp_err ? NOP : imem_resp_data;
        r_cmd_pc <= r_pc;
        r_fault  <= imem_resp_err;
      end else if (w_mis_load) begin
        r_cmd    <= NOP;
        r_cmd_pc <= redirect_pc;
        r_fault  <= 1'b1;
      end
    end
  end

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_addr      = r_pc;
  assign cmd_valid      = (r_state == S_HOLD);
  assign cmd            = r_cmd;
  assign cmd_pc         = r_cmd_pc;
  assign cmd_fault      = r_fault;

endmodule
